// File: rtl/snax_alu_pkg.sv
// Shared types for the SNAX ALU job scheduler: ALU modes, job descriptor, FSM states.
package snax_alu_pkg;

  localparam int unsigned JobModeWidth = 2;
  localparam int unsigned JobLenWidth  = 32;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    XOR = 2'd3
  } alu_mode_e;

  typedef struct packed {
    logic [JobModeWidth-1:0] mode;
    logic [JobLenWidth-1:0]  len;
  } job_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/snax_alu_job_fifo.sv
// Circular job queue; head is visible combinationally, push/pop take effect on the clock edge.
// A push while full or a pop while empty is ignored; the level counter separates full from empty.
module snax_alu_job_fifo
  import snax_alu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  job_t                     push_dat_i,
  input  logic                     pop_i,
  output job_t                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW+1)'(Depth);

  job_t            mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_o == LevelFull);
  assign empty_o = (level_o == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
    end
  end

endmodule

// File: rtl/snax_alu_job_scheduler.sv
// Issues queued ALU jobs one at a time to the PE array; acc_ready_o rises one cycle after a pop.
// job_ready_o drops only when the queue is full; retirement and next-job pop share a cycle (no bubble).
module snax_alu_job_scheduler
  import snax_alu_pkg::*;
#(
  parameter int unsigned JobDepth     = 4,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ModeWidth-1:0]          job_mode_i,
  input  logic [RegDataWidth-1:0]       job_len_i,
  input  logic                          job_valid_i,
  output logic                          job_ready_o,
  input  logic                          acc_output_success_i,
  output logic                          acc_ready_o,
  output logic [ModeWidth-1:0]          alu_config_o,
  output logic                          busy_o,
  output logic [$clog2(JobDepth):0]     queue_level_o,
  output logic [RegDataWidth-1:0]       jobs_done_o,
  output logic [RegDataWidth-1:0]       busy_cycles_o
);

  sched_state_e            state;
  sched_state_e            next_state;
  logic [RegDataWidth-1:0] remaining;
  job_t                    push_job;
  job_t                    head;
  logic                    q_full;
  logic                    q_empty;
  logic                    pop;
  logic                    load;
  logic [1:0]              retire_cnt;
  logic                    head_zero;

  assign push_job.mode = job_mode_i;
  assign push_job.len  = job_len_i;
  assign job_ready_o   = !q_full;
  assign busy_o        = (state == RUN) || !q_empty;
  assign head_zero     = (head.len == '0);

  snax_alu_job_fifo #(
    .Depth(JobDepth)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (job_valid_i),
    .push_dat_i(push_job),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (q_full),
    .empty_o   (q_empty),
    .level_o   (queue_level_o)
  );

  // Zero-length heads are retired on pop without ever becoming the active job.
  always_comb begin
    pop        = 1'b0;
    load       = 1'b0;
    retire_cnt = 2'd0;
    next_state = state;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop = 1'b1;
          if (head_zero) begin
            retire_cnt = 2'd1;
          end else begin
            load       = 1'b1;
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (acc_output_success_i && remaining == RegDataWidth'(1)) begin
          retire_cnt = 2'd1;
          next_state = IDLE;
          if (!q_empty) begin
            pop = 1'b1;
            if (head_zero) begin
              retire_cnt = 2'd2;
            end else begin
              load       = 1'b1;
              next_state = RUN;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      acc_ready_o   <= 1'b0;
      alu_config_o  <= '0;
      remaining     <= '0;
      jobs_done_o   <= '0;
      busy_cycles_o <= '0;
    end else begin
      state       <= next_state;
      acc_ready_o <= (next_state == RUN);
      if (load) begin
        alu_config_o <= head.mode;
        remaining    <= head.len;
      end else if (state == RUN && acc_output_success_i) begin
        remaining <= remaining - 1'b1;
      end
      jobs_done_o <= jobs_done_o + RegDataWidth'(retire_cnt);
      if (busy_o && busy_cycles_o != '1) busy_cycles_o <= busy_cycles_o + 1'b1;
    end
  end

  // Output handshakes are only legal while a job is issued.
  a_no_success_in_idle : assert property (@(posedge clk_i) disable iff (rst_i)
      !(acc_output_success_i && state == IDLE))
    else $error("acc_output_success_i asserted while scheduler idle");

endmodule

// File: tb/tb_snax_alu_job_scheduler.sv
// Directed bench for snax_alu_job_scheduler with hand-computed expectations.
module tb_snax_alu_job_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  job_mode_i;
  logic [31:0] job_len_i;
  logic        job_valid_i;
  logic        job_ready_o;
  logic        acc_output_success_i;
  logic        acc_ready_o;
  logic [1:0]  alu_config_o;
  logic        busy_o;
  logic [2:0]  queue_level_o;
  logic [31:0] jobs_done_o;
  logic [31:0] busy_cycles_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  snax_alu_job_scheduler #(
    .JobDepth(4), .RegDataWidth(32), .ModeWidth(2)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .job_mode_i          (job_mode_i),
    .job_len_i           (job_len_i),
    .job_valid_i         (job_valid_i),
    .job_ready_o         (job_ready_o),
    .acc_output_success_i(acc_output_success_i),
    .acc_ready_o         (acc_ready_o),
    .alu_config_o        (alu_config_o),
    .busy_o              (busy_o),
    .queue_level_o       (queue_level_o),
    .jobs_done_o         (jobs_done_o),
    .busy_cycles_o       (busy_cycles_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds a success beat whenever the array is enabled until the block goes idle.
  task automatic drain(input int bound);
    int n = 0;
    while ((busy_o || acc_ready_o) && n < bound) begin
      acc_output_success_i = acc_ready_o;
      tick();
      n++;
    end
    acc_output_success_i = 1'b0;
    chk("drain_in_budget", 64'(n < bound), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_job_ready"},   64'(job_ready_o),   64'd1);
    chk({tag, "_acc_ready"},   64'(acc_ready_o),   64'd0);
    chk({tag, "_busy"},        64'(busy_o),        64'd0);
    chk({tag, "_level"},       64'(queue_level_o), 64'd0);
    chk({tag, "_jobs_done"},   64'(jobs_done_o),   64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_cycles_o), 64'd0);
    chk({tag, "_alu_config"},  64'(alu_config_o),  64'd0);
  endtask

  initial begin
    rst_i                = 1'b1;
    job_mode_i           = 2'd0;
    job_len_i            = 32'd0;
    job_valid_i          = 1'b0;
    acc_output_success_i = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    rst_i = 1'b0;
    tick();

    // Single MUL job of 3 beats: issue two cycles after the push.
    job_valid_i = 1'b1; job_mode_i = 2'd2; job_len_i = 32'd3;
    tick();
    job_valid_i = 1'b0;
    chk("mul_n1_acc_ready", 64'(acc_ready_o), 64'd0);
    chk("mul_n1_level",     64'(queue_level_o), 64'd1);
    chk("mul_n1_busy",      64'(busy_o), 64'd1);
    tick();
    chk("mul_n2_acc_ready", 64'(acc_ready_o), 64'd1);
    chk("mul_n2_config",    64'(alu_config_o), 64'd2);
    chk("mul_n2_level",     64'(queue_level_o), 64'd0);
    acc_output_success_i = 1'b1;
    tick(); tick(); tick();
    acc_output_success_i = 1'b0;
    chk("mul_done_jobs",     64'(jobs_done_o), 64'd1);
    chk("mul_done_busy",     64'(busy_o), 64'd0);
    chk("mul_done_acc",      64'(acc_ready_o), 64'd0);
    chk("mul_busy_cycles",   64'(busy_cycles_o), 64'd4);

    // ADD,2 then SUB,2 back to back without an acc_ready gap.
    job_valid_i = 1'b1; job_mode_i = 2'd0; job_len_i = 32'd2;
    tick();
    job_mode_i = 2'd1;
    tick();
    job_valid_i = 1'b0;
    chk("b2b_c0_acc", 64'(acc_ready_o), 64'd1);
    chk("b2b_c0_cfg", 64'(alu_config_o), 64'd0);
    acc_output_success_i = 1'b1;
    tick();
    chk("b2b_c1_acc", 64'(acc_ready_o), 64'd1);
    chk("b2b_c1_cfg", 64'(alu_config_o), 64'd0);
    tick();
    chk("b2b_c2_acc", 64'(acc_ready_o), 64'd1);
    chk("b2b_c2_cfg", 64'(alu_config_o), 64'd1);
    tick();
    chk("b2b_c3_acc", 64'(acc_ready_o), 64'd1);
    chk("b2b_c3_cfg", 64'(alu_config_o), 64'd1);
    tick();
    acc_output_success_i = 1'b0;
    chk("b2b_end_acc",  64'(acc_ready_o), 64'd0);
    chk("b2b_end_jobs", 64'(jobs_done_o), 64'd3);

    // Five len-10 jobs fill active slot plus queue; sixth push stalls.
    job_valid_i = 1'b1; job_len_i = 32'd10;
    for (int i = 0; i < 5; i++) begin
      job_mode_i = 2'(i);
      tick();
    end
    job_mode_i = 2'd1; job_len_i = 32'd2;
    chk("full_ready", 64'(job_ready_o), 64'd0);
    chk("full_level", 64'(queue_level_o), 64'd4);
    chk("full_cfg",   64'(alu_config_o), 64'd0);
    acc_output_success_i = 1'b1;
    repeat (9) tick();
    chk("full_stall_ready", 64'(job_ready_o), 64'd0);
    tick();
    chk("full_retire_ready", 64'(job_ready_o), 64'd1);
    chk("full_retire_level", 64'(queue_level_o), 64'd3);
    chk("full_retire_cfg",   64'(alu_config_o), 64'd1);
    chk("full_retire_jobs",  64'(jobs_done_o), 64'd4);
    tick();
    job_valid_i = 1'b0;
    chk("full_sixth_level", 64'(queue_level_o), 64'd4);
    drain(200);
    chk("full_drain_jobs",  64'(jobs_done_o), 64'd9);
    chk("full_drain_level", 64'(queue_level_o), 64'd0);

    // Zero-length XOR retires from IDLE without issuing; ADD,1 follows.
    job_valid_i = 1'b1; job_mode_i = 2'd3; job_len_i = 32'd0;
    tick();
    job_mode_i = 2'd0; job_len_i = 32'd1;
    tick();
    job_valid_i = 1'b0;
    chk("zl_acc",   64'(acc_ready_o), 64'd0);
    chk("zl_jobs",  64'(jobs_done_o), 64'd10);
    chk("zl_cfg",   64'(alu_config_o), 64'd1);
    chk("zl_level", 64'(queue_level_o), 64'd1);
    tick();
    chk("zl_add_acc", 64'(acc_ready_o), 64'd1);
    chk("zl_add_cfg", 64'(alu_config_o), 64'd0);
    acc_output_success_i = 1'b1;
    tick();
    acc_output_success_i = 1'b0;
    chk("zl_add_done_acc",  64'(acc_ready_o), 64'd0);
    chk("zl_add_done_jobs", 64'(jobs_done_o), 64'd11);

    // Zero-length head at retirement: both retire in one cycle, FSM idles.
    job_valid_i = 1'b1; job_mode_i = 2'd1; job_len_i = 32'd1;
    tick();
    job_mode_i = 2'd3; job_len_i = 32'd0;
    tick();
    job_valid_i = 1'b0;
    chk("zlrun_acc", 64'(acc_ready_o), 64'd1);
    acc_output_success_i = 1'b1;
    tick();
    acc_output_success_i = 1'b0;
    chk("zlrun_jobs",  64'(jobs_done_o), 64'd13);
    chk("zlrun_acc2",  64'(acc_ready_o), 64'd0);
    chk("zlrun_level", 64'(queue_level_o), 64'd0);
    chk("zlrun_busy",  64'(busy_o), 64'd0);
    chk("zlrun_cfg",   64'(alu_config_o), 64'd1);

    // Reset mid-job with 5 beats remaining and 2 jobs queued.
    job_valid_i = 1'b1; job_mode_i = 2'd2; job_len_i = 32'd6;
    tick();
    job_mode_i = 2'd1; job_len_i = 32'd3;
    tick();
    chk("rstmid_acc", 64'(acc_ready_o), 64'd1);
    acc_output_success_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
    acc_output_success_i = 1'b0;
    chk("rstmid_level", 64'(queue_level_o), 64'd2);
    #2 rst_i = 1'b1;
    #1;
    check_reset_values("rstmid");
    tick();
    rst_i = 1'b0;
    tick();
    job_valid_i = 1'b1; job_mode_i = 2'd3; job_len_i = 32'd2;
    tick();
    job_valid_i = 1'b0;
    tick();
    chk("post_rst_acc", 64'(acc_ready_o), 64'd1);
    chk("post_rst_cfg", 64'(alu_config_o), 64'd3);
    drain(50);
    chk("post_rst_jobs", 64'(jobs_done_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
